// File: rtl/mig_arb_pkg.sv
// Shared types and constants for the MIG app-port arbiter: FSM states, MIG
// command encodings and default address/data widths.
package mig_arb_pkg;

  localparam int ADDR_W_DEFAULT = 29;
  localparam int DATA_W_DEFAULT = 256;

  localparam logic [2:0] CMD_WRITE = 3'b000;
  localparam logic [2:0] CMD_READ  = 3'b001;

  typedef enum logic [1:0] {
    S_CALIB = 2'd0,
    S_IDLE  = 2'd1,
    S_WRITE = 2'd2,
    S_READ  = 2'd3
  } state_e;

endpackage

// File: rtl/mig_app_arbiter_if.sv
// Requester, read-return and MIG app-port signals of mig_app_arbiter.
// slave = the arbiter, master = the surrounding requesters and MIG model.
interface mig_app_arbiter_if
  import mig_arb_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEFAULT,
  parameter int DATA_W  = DATA_W_DEFAULT,
  parameter int MAX_OUT = 16
);
  localparam int CNT_W = $clog2(MAX_OUT) + 1;

  logic              init_calib_complete;
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ack;
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_ack;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic [ADDR_W-1:0] app_addr;
  logic [2:0]        app_cmd;
  logic              app_en;
  logic [DATA_W-1:0] app_wdf_data;
  logic              app_wdf_wren;
  logic              app_wdf_end;
  logic              app_rdy;
  logic              app_wdf_rdy;
  logic [DATA_W-1:0] app_rd_data;
  logic              app_rd_data_valid;
  logic [CNT_W-1:0]  rd_outstanding;

  modport slave (
    input  init_calib_complete, wr_req, wr_addr, wr_data, rd_req, rd_addr,
           app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid,
    output wr_ack, rd_ack, rd_data, rd_valid, app_addr, app_cmd, app_en,
           app_wdf_data, app_wdf_wren, app_wdf_end, rd_outstanding
  );

  modport master (
    output init_calib_complete, wr_req, wr_addr, wr_data, rd_req, rd_addr,
           app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid,
    input  wr_ack, rd_ack, rd_data, rd_valid, app_addr, app_cmd, app_en,
           app_wdf_data, app_wdf_wren, app_wdf_end, rd_outstanding
  );

endinterface

// File: rtl/mig_arb_rd_tracker.sv
// Saturating count of reads accepted by the MIG whose data has not yet
// returned; simultaneous inc/dec leaves the count unchanged.
module mig_arb_rd_tracker #(
  parameter int MAX_OUT = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     inc,
  input  logic                     dec,
  output logic                     full,
  output logic [$clog2(MAX_OUT):0] count
);
  localparam int                CNT_W   = $clog2(MAX_OUT) + 1;
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUT);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  logic [CNT_W-1:0] count_q, count_d;

  // Next count: guarded at both ends so it can never wrap.
  always_comb begin
    count_d = count_q;
    case ({inc, dec})
      2'b10: begin
        if (count_q != MAX_CNT) count_d = count_q + ONE;
        else                    count_d = count_q;
      end
      2'b01: begin
        if (count_q != {CNT_W{1'b0}}) count_d = count_q - ONE;
        else                          count_d = count_q;
      end
      default: count_d = count_q;
    endcase
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= {CNT_W{1'b0}};
    else        count_q <= count_d;
  end

  assign full  = (count_q == MAX_CNT);
  assign count = count_q;

endmodule

// File: rtl/mig_app_arbiter.sv
// Arbitrates one write and one read requester onto the MIG app port.
// Define MIG_ARB_RR_EN for round-robin; otherwise read has fixed priority.
module mig_app_arbiter
  import mig_arb_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEFAULT,
  parameter int DATA_W  = DATA_W_DEFAULT,
  parameter int MAX_OUT = 16
) (
  input  logic             ui_clk,
  input  logic             sys_rst,
  mig_app_arbiter_if.slave bus
);
  localparam int CNT_W = $clog2(MAX_OUT) + 1;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] app_addr_q, app_addr_d;
  logic [DATA_W-1:0] app_wdf_data_q, app_wdf_data_d;
  logic [2:0]        app_cmd_q, app_cmd_d;
  logic              app_en_q, app_en_d;
  logic              app_wdf_wren_q, app_wdf_wren_d;
  logic [DATA_W-1:0] rd_data_q;
  logic              rd_valid_q;
  logic              rd_elig_s, grant_wr_s, grant_rd_s, rd_accept_s, rd_full_s;
  logic [CNT_W-1:0]  rd_count_s;

`ifdef MIG_ARB_RR_EN
  logic last_wr_q;

  // Port served most recently; reset value makes read win the first tie.
  always_ff @(posedge ui_clk or negedge sys_rst) begin
    if (!sys_rst)        last_wr_q <= 1'b1;
    else if (grant_wr_s) last_wr_q <= 1'b1;
    else if (grant_rd_s) last_wr_q <= 1'b0;
    else                 last_wr_q <= last_wr_q;
  end
`endif

  // Grant decision, only while idle; reads are held off once the tracker is full.
  always_comb begin
    grant_wr_s = 1'b0;
    grant_rd_s = 1'b0;
    rd_elig_s  = bus.rd_req && !rd_full_s;
    if (state_q == S_IDLE) begin
`ifdef MIG_ARB_RR_EN
      if (rd_elig_s && bus.wr_req) begin
        grant_rd_s = last_wr_q;
        grant_wr_s = !last_wr_q;
      end else begin
        grant_rd_s = rd_elig_s;
        grant_wr_s = bus.wr_req;
      end
`else
      grant_rd_s = rd_elig_s;
      grant_wr_s = bus.wr_req && !rd_elig_s;
`endif
    end else begin
      grant_wr_s = 1'b0;
      grant_rd_s = 1'b0;
    end
  end

  // Next state and command capture; the command is held until the MIG takes it.
  always_comb begin
    state_d        = state_q;
    app_addr_d     = app_addr_q;
    app_wdf_data_d = app_wdf_data_q;
    app_cmd_d      = app_cmd_q;
    app_en_d       = app_en_q;
    app_wdf_wren_d = app_wdf_wren_q;
    case (state_q)
      S_CALIB: begin
        if (bus.init_calib_complete) state_d = S_IDLE;
        else                         state_d = S_CALIB;
      end
      S_IDLE: begin
        if (grant_wr_s) begin
          state_d        = S_WRITE;
          app_addr_d     = bus.wr_addr;
          app_wdf_data_d = bus.wr_data;
          app_cmd_d      = CMD_WRITE;
          app_en_d       = 1'b1;
          app_wdf_wren_d = 1'b1;
        end else if (grant_rd_s) begin
          state_d        = S_READ;
          app_addr_d     = bus.rd_addr;
          app_cmd_d      = CMD_READ;
          app_en_d       = 1'b1;
          app_wdf_wren_d = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WRITE: begin
        if (bus.app_rdy && bus.app_wdf_rdy) begin
          state_d        = S_IDLE;
          app_en_d       = 1'b0;
          app_wdf_wren_d = 1'b0;
        end else begin
          state_d = S_WRITE;
        end
      end
      S_READ: begin
        if (bus.app_rdy) begin
          state_d  = S_IDLE;
          app_en_d = 1'b0;
        end else begin
          state_d = S_READ;
        end
      end
      default: begin
        state_d        = S_CALIB;
        app_en_d       = 1'b0;
        app_wdf_wren_d = 1'b0;
      end
    endcase
  end

  // State and MIG command registers.
  always_ff @(posedge ui_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state_q        <= S_CALIB;
      app_addr_q     <= {ADDR_W{1'b0}};
      app_wdf_data_q <= {DATA_W{1'b0}};
      app_cmd_q      <= CMD_WRITE;
      app_en_q       <= 1'b0;
      app_wdf_wren_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      app_addr_q     <= app_addr_d;
      app_wdf_data_q <= app_wdf_data_d;
      app_cmd_q      <= app_cmd_d;
      app_en_q       <= app_en_d;
      app_wdf_wren_q <= app_wdf_wren_d;
    end
  end

  // Read return is forwarded even when no read is outstanding.
  always_ff @(posedge ui_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      rd_data_q  <= {DATA_W{1'b0}};
      rd_valid_q <= 1'b0;
    end else begin
      rd_data_q  <= bus.app_rd_data;
      rd_valid_q <= bus.app_rd_data_valid;
    end
  end

  assign rd_accept_s = (state_q == S_READ) && bus.app_rdy;

  mig_arb_rd_tracker #(.MAX_OUT(MAX_OUT)) u_rd_tracker (
    .clk   (ui_clk),
    .rst_n (sys_rst),
    .inc   (rd_accept_s),
    .dec   (bus.app_rd_data_valid),
    .full  (rd_full_s),
    .count (rd_count_s)
  );

  assign bus.wr_ack         = grant_wr_s;
  assign bus.rd_ack         = grant_rd_s;
  assign bus.app_addr       = app_addr_q;
  assign bus.app_wdf_data   = app_wdf_data_q;
  assign bus.app_cmd        = app_cmd_q;
  assign bus.app_en         = app_en_q;
  assign bus.app_wdf_wren   = app_wdf_wren_q;
  assign bus.app_wdf_end    = app_wdf_wren_q;
  assign bus.rd_data        = rd_data_q;
  assign bus.rd_valid       = rd_valid_q;
  assign bus.rd_outstanding = rd_count_s;

endmodule

// File: tb/tb_mig_app_arbiter.sv
// Self-checking bench for mig_app_arbiter: vector table, directed corner
// sequences and a randomized run against a transaction-level model.
module tb_mig_app_arbiter;
  import mig_arb_pkg::*;

  localparam int AW = 29;
  localparam int DW = 256;
  localparam int MO = 16;
`ifdef MIG_ARB_RR_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  logic ui_clk  = 1'b0;
  logic sys_rst = 1'b0;
  int   total   = 0;
  int   bad     = 0;

  always #5 ui_clk = ~ui_clk;

  mig_app_arbiter_if #(.ADDR_W(AW), .DATA_W(DW), .MAX_OUT(MO)) bus ();

  mig_app_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_OUT(MO)) dut (
    .ui_clk  (ui_clk),
    .sys_rst (sys_rst),
    .bus     (bus)
  );

  typedef struct {
    logic          is_rd;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int            stall;
    logic [2:0]    exp_cmd;
    logic          exp_wren;
  } vec_t;
  vec_t vecs[5];

  // transaction-level reference state
  logic          m_cal, m_busy, m_is_rd, m_last_wr, m_rv;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data, m_rd;
  logic [2:0]    m_cmd;
  int            m_out;

  task automatic chkb(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0b want %0b", name, act, exp);
    end
  endtask

  task automatic chkw(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge ui_clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] d;
    for (int j = 0; j < DW / 32; j++) d[j*32 +: 32] = $urandom;
    return d;
  endfunction

  task automatic drive_idle();
    bus.wr_req            = 1'b0;
    bus.rd_req            = 1'b0;
    bus.wr_addr           = '0;
    bus.rd_addr           = '0;
    bus.wr_data           = '0;
    bus.app_rdy           = 1'b0;
    bus.app_wdf_rdy       = 1'b0;
    bus.app_rd_data       = '0;
    bus.app_rd_data_valid = 1'b0;
  endtask

  task automatic do_reset();
    tick();
    sys_rst = 1'b0;
    drive_idle();
    bus.init_calib_complete = 1'b0;
    tick();
    tick();
    sys_rst = 1'b1;
    bus.init_calib_complete = 1'b1;
    tick();
    tick();
  endtask

  task automatic model_reset();
    m_cal = 1'b0; m_busy = 1'b0; m_is_rd = 1'b0; m_last_wr = 1'b1; m_rv = 1'b0;
    m_addr = '0; m_data = '0; m_rd = '0; m_cmd = CMD_WRITE; m_out = 0;
  endtask

  // One cycle of the reference: predict and compare outputs, then advance.
  task automatic model_cycle(output logic g_wr, output logic g_rd);
    logic rd_ok, acc, done;
    rd_ok = bus.rd_req && (m_out < MO);
    g_wr = 1'b0;
    g_rd = 1'b0;
    if (m_cal && !m_busy) begin
      if (rd_ok && bus.wr_req) begin
        g_rd = RR_EN ? m_last_wr : 1'b1;
        g_wr = !g_rd;
      end else begin
        g_rd = rd_ok;
        g_wr = bus.wr_req;
      end
    end
    chkb("m_wr_ack", bus.wr_ack, g_wr);
    chkb("m_rd_ack", bus.rd_ack, g_rd);
    chkb("m_app_en", bus.app_en, m_busy);
    chkb("m_wren", bus.app_wdf_wren, m_busy && !m_is_rd);
    chkb("m_wdf_end", bus.app_wdf_end, m_busy && !m_is_rd);
    chkw("m_cmd", DW'(bus.app_cmd), DW'(m_cmd));
    chkw("m_addr", DW'(bus.app_addr), DW'(m_addr));
    chkw("m_wdata", bus.app_wdf_data, m_data);
    chkw("m_outstanding", DW'(bus.rd_outstanding), DW'(m_out));
    chkb("m_rd_valid", bus.rd_valid, m_rv);
    if (m_rv) chkw("m_rd_data", bus.rd_data, m_rd);

    acc  = m_busy && m_is_rd && bus.app_rdy;
    done = m_busy && bus.app_rdy && (m_is_rd || bus.app_wdf_rdy);
    if (!m_cal) m_cal = bus.init_calib_complete;
    else if (m_busy) begin
      if (done) m_busy = 1'b0;
    end else if (g_wr) begin
      m_busy = 1'b1; m_is_rd = 1'b0; m_addr = bus.wr_addr; m_data = bus.wr_data;
      m_cmd = CMD_WRITE; m_last_wr = 1'b1;
    end else if (g_rd) begin
      m_busy = 1'b1; m_is_rd = 1'b1; m_addr = bus.rd_addr;
      m_cmd = CMD_READ; m_last_wr = 1'b0;
    end
    if (acc && !bus.app_rd_data_valid) m_out++;
    else if (!acc && bus.app_rd_data_valid && m_out > 0) m_out--;
    m_rv = bus.app_rd_data_valid;
    m_rd = bus.app_rd_data;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] d0;
    int n, nrd, nwr, exp_out;
    logic found, g_wr, g_rd, wr_g, rd_g;

    vecs[0] = '{1'b0, 29'h10,        256'h2,                   5, CMD_WRITE, 1'b1};
    vecs[1] = '{1'b1, 29'h1ABC,      256'h0,                   3, CMD_READ,  1'b0};
    vecs[2] = '{1'b0, 29'h1FFF_FFFF, {256{1'b1}},              0, CMD_WRITE, 1'b1};
    vecs[3] = '{1'b1, 29'h0,         256'h0,                   0, CMD_READ,  1'b0};
    vecs[4] = '{1'b0, 29'h0ABC_DEF,  256'hDEAD_BEEF_0123_4567, 2, CMD_WRITE, 1'b1};

    // reset state, with a write request present that must not be acked
    drive_idle();
    bus.init_calib_complete = 1'b0;
    bus.wr_req = 1'b1;
    repeat (3) tick();
    settle();
    chkb("rst_app_en", bus.app_en, 1'b0);
    chkb("rst_wren", bus.app_wdf_wren, 1'b0);
    chkb("rst_wdf_end", bus.app_wdf_end, 1'b0);
    chkw("rst_cmd", DW'(bus.app_cmd), DW'(3'b000));
    chkw("rst_addr", DW'(bus.app_addr), '0);
    chkw("rst_wdata", bus.app_wdf_data, '0);
    chkb("rst_wr_ack", bus.wr_ack, 1'b0);
    chkb("rst_rd_ack", bus.rd_ack, 1'b0);
    chkb("rst_rd_valid", bus.rd_valid, 1'b0);
    chkw("rst_rd_data", bus.rd_data, '0);
    chkw("rst_outstanding", DW'(bus.rd_outstanding), '0);

    // calibration gating
    tick();
    sys_rst = 1'b1;
    d0 = rand_data();
    bus.wr_req = 1'b1; bus.wr_addr = 29'h5; bus.wr_data = d0;
    bus.app_rdy = 1'b1; bus.app_wdf_rdy = 1'b1;
    for (int c = 0; c < 50; c++) begin
      settle();
      chkb("calib_no_ack", bus.wr_ack, 1'b0);
      chkb("calib_no_en", bus.app_en, 1'b0);
      tick();
    end
    bus.init_calib_complete = 1'b1;
    settle();
    chkb("calib_rise_no_ack", bus.wr_ack, 1'b0);
    tick(); settle();
    chkb("calib_wr_ack", bus.wr_ack, 1'b1);
    chkb("calib_en_low", bus.app_en, 1'b0);
    tick();
    bus.wr_req = 1'b0;
    settle();
    chkb("calib_en", bus.app_en, 1'b1);
    chkb("calib_wren", bus.app_wdf_wren, 1'b1);
    chkb("calib_wdf_end", bus.app_wdf_end, 1'b1);
    chkw("calib_cmd", DW'(bus.app_cmd), DW'(CMD_WRITE));
    chkw("calib_addr", DW'(bus.app_addr), DW'(29'h5));
    chkw("calib_wdata", bus.app_wdf_data, d0);
    tick(); settle();
    chkb("calib_done", bus.app_en, 1'b0);

    // table of single transactions with MIG back-pressure
    exp_out = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      bus.app_rdy = 1'b0; bus.app_wdf_rdy = 1'b0;
      if (vecs[i].is_rd) begin
        bus.rd_req = 1'b1; bus.rd_addr = vecs[i].addr;
      end else begin
        bus.wr_req = 1'b1; bus.wr_addr = vecs[i].addr; bus.wr_data = vecs[i].data;
      end
      settle();
      chkb("tbl_wr_ack", bus.wr_ack, !vecs[i].is_rd);
      chkb("tbl_rd_ack", bus.rd_ack, vecs[i].is_rd);
      tick();
      bus.wr_req = 1'b0; bus.rd_req = 1'b0;
      bus.app_rdy = !vecs[i].is_rd; bus.app_wdf_rdy = vecs[i].is_rd;
      for (int s = 0; s <= vecs[i].stall; s++) begin
        if (s == vecs[i].stall) begin bus.app_rdy = 1'b1; bus.app_wdf_rdy = 1'b1; end
        settle();
        chkb("tbl_en", bus.app_en, 1'b1);
        chkw("tbl_cmd", DW'(bus.app_cmd), DW'(vecs[i].exp_cmd));
        chkb("tbl_wren", bus.app_wdf_wren, vecs[i].exp_wren);
        chkb("tbl_wdf_end", bus.app_wdf_end, vecs[i].exp_wren);
        chkw("tbl_addr", DW'(bus.app_addr), DW'(vecs[i].addr));
        if (!vecs[i].is_rd) chkw("tbl_wdata", bus.app_wdf_data, vecs[i].data);
        tick();
      end
      if (vecs[i].is_rd) exp_out++;
      bus.app_rdy = 1'b0;
      settle();
      chkb("tbl_idle_en", bus.app_en, 1'b0);
      chkb("tbl_idle_wren", bus.app_wdf_wren, 1'b0);
      chkw("tbl_outstanding", DW'(bus.rd_outstanding), DW'(exp_out));
    end

    // return data for the two table reads
    for (int k = 0; k < 2; k++) begin
      tick();
      d0 = rand_data();
      bus.app_rd_data_valid = 1'b1; bus.app_rd_data = d0;
      settle();
      tick();
      bus.app_rd_data_valid = 1'b0;
      settle();
      exp_out--;
      chkb("ret_valid", bus.rd_valid, 1'b1);
      chkw("ret_data", bus.rd_data, d0);
      chkw("ret_outstanding", DW'(bus.rd_outstanding), DW'(exp_out));
    end

    // both requesters held continuously
    do_reset();
    bus.wr_req = 1'b1; bus.rd_req = 1'b1; bus.wr_addr = 29'h100; bus.rd_addr = 29'h200;
    bus.app_rdy = 1'b1; bus.app_wdf_rdy = 1'b1;
    n = 0; nrd = 0; nwr = 0;
    for (int c = 0; c < 60 && n < 8; c++) begin
      settle();
      if (bus.rd_ack || bus.wr_ack) begin
        chkb("arb_single_ack", bus.rd_ack && bus.wr_ack, 1'b0);
        chkb("arb_order", bus.rd_ack, RR_EN ? (n % 2 == 0) : 1'b1);
        if (bus.rd_ack) nrd++; else nwr++;
        n++;
      end
      tick();
    end
    chkw("arb_grants", DW'(n), DW'(8));
    chkw("arb_rd_acks", DW'(nrd), RR_EN ? DW'(4) : DW'(8));
    chkw("arb_wr_acks", DW'(nwr), RR_EN ? DW'(4) : DW'(0));

    // read burst into a full tracker
    do_reset();
    bus.rd_req = 1'b1; bus.rd_addr = 29'h40; bus.app_rdy = 1'b1; bus.app_wdf_rdy = 1'b1;
    n = 0;
    for (int c = 0; c < 80; c++) begin
      settle();
      if (bus.rd_ack) n++;
      if (c > 40) chkb("full_no_rd_ack", bus.rd_ack, 1'b0);
      if (n == 20) bus.rd_req = 1'b0;
      tick();
    end
    chkw("burst_acks", DW'(n), DW'(16));
    chkw("burst_outstanding", DW'(bus.rd_outstanding), DW'(16));
    d0 = rand_data();
    bus.app_rd_data_valid = 1'b1; bus.app_rd_data = d0;
    settle();
    tick();
    bus.app_rd_data_valid = 1'b0;
    settle();
    chkb("burst_ret_valid", bus.rd_valid, 1'b1);
    chkw("burst_ret_data", bus.rd_data, d0);
    n = int'(bus.rd_ack);
    tick();
    for (int c = 0; c < 9; c++) begin
      settle();
      if (bus.rd_ack) n++;
      tick();
    end
    chkw("burst_one_more", DW'(n), DW'(1));
    chkw("burst_refull", DW'(bus.rd_outstanding), DW'(16));
    bus.wr_req = 1'b1; bus.wr_addr = 29'h77; bus.wr_data = rand_data();
    found = 1'b0;
    for (int c = 0; c < 6 && !found; c++) begin
      settle();
      if (bus.wr_ack) found = 1'b1;
      tick();
    end
    chkb("full_write_granted", found, 1'b1);
    bus.wr_req = 1'b0; bus.rd_req = 1'b0;

    // simultaneous accept and return at count 5
    bus.app_rd_data_valid = 1'b1;
    for (int k = 0; k < 11; k++) begin
      settle();
      tick();
    end
    bus.app_rd_data_valid = 1'b0;
    settle();
    chkw("drain_to_5", DW'(bus.rd_outstanding), DW'(5));
    tick();
    bus.rd_req = 1'b1; bus.rd_addr = 29'h55; bus.app_rdy = 1'b0;
    settle();
    chkb("same_rd_ack", bus.rd_ack, 1'b1);
    tick();
    bus.rd_req = 1'b0; bus.app_rdy = 1'b1;
    d0 = rand_data();
    bus.app_rd_data_valid = 1'b1; bus.app_rd_data = d0;
    settle();
    chkb("same_en", bus.app_en, 1'b1);
    tick();
    bus.app_rd_data_valid = 1'b0;
    settle();
    chkw("same_count", DW'(bus.rd_outstanding), DW'(5));
    chkb("same_rd_valid", bus.rd_valid, 1'b1);
    chkw("same_rd_data", bus.rd_data, d0);

    // asynchronous reset in the middle of a write
    tick();
    bus.wr_req = 1'b1; bus.wr_addr = 29'h99; bus.app_rdy = 1'b0; bus.app_wdf_rdy = 1'b0;
    settle();
    chkb("arst_wr_ack", bus.wr_ack, 1'b1);
    tick();
    bus.wr_req = 1'b0;
    settle();
    chkb("arst_en_before", bus.app_en, 1'b1);
    #1;
    sys_rst = 1'b0;
    #1;
    chkb("arst_en", bus.app_en, 1'b0);
    chkb("arst_wren", bus.app_wdf_wren, 1'b0);
    chkw("arst_addr", DW'(bus.app_addr), '0);
    chkw("arst_outstanding", DW'(bus.rd_outstanding), '0);
    tick();
    sys_rst = 1'b1;
    bus.init_calib_complete = 1'b0;
    bus.wr_req = 1'b1;
    for (int c = 0; c < 5; c++) begin
      settle();
      chkb("arst_calib_no_ack", bus.wr_ack, 1'b0);
      chkb("arst_calib_no_en", bus.app_en, 1'b0);
      tick();
    end
    bus.init_calib_complete = 1'b1;
    tick();
    settle();
    chkb("arst_recal_ack", bus.wr_ack, 1'b1);

    // randomized run against the reference model
    tick();
    sys_rst = 1'b0;
    drive_idle();
    bus.init_calib_complete = 1'b0;
    tick();
    model_reset();
    sys_rst = 1'b1;
    wr_g = 1'b0; rd_g = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      if (c >= 8) bus.init_calib_complete = (c == 8) ? 1'b1 : ($urandom % 16 != 0);
      if (!bus.wr_req || wr_g) begin
        bus.wr_req = ($urandom % 3 == 0); bus.wr_addr = AW'($urandom); bus.wr_data = rand_data();
      end
      if (!bus.rd_req || rd_g) begin
        bus.rd_req = ($urandom % 2 == 0); bus.rd_addr = AW'($urandom);
      end
      bus.app_rd_data_valid = ($urandom % 100) < (((c / 250) % 2 == 1) ? 45 : 5);
      bus.app_rd_data = rand_data();
      bus.app_rdy     = ($urandom % 4 != 0);
      bus.app_wdf_rdy = ($urandom % 3 != 0);
      settle();
      model_cycle(g_wr, g_rd);
      wr_g = g_wr;
      rd_g = g_rd;
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mig_app_arbiter.md
MIG_APP_ARBITER -- requirements
Module: mig_app_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, 29, MIG app address width.
REQ-002 SHALL have parameter DATA_W, 256, MIG app data width.
REQ-003 SHALL have parameter MAX_OUT, 16, maximum outstanding reads (power of two, 2..32).
REQ-004 SHALL have port ui_clk  in  1  single clock for the block.
REQ-005 SHALL have port sys_rst  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port init_calib_complete  in  1  MIG calibration done.
REQ-007 SHALL have ports wr_req in 1, wr_addr in ADDR_W, wr_data in DATA_W, wr_ack out 1: write requester.
REQ-008 SHALL have ports rd_req in 1, rd_addr in ADDR_W, rd_ack out 1: read requester.
REQ-009 SHALL have ports rd_data out DATA_W, rd_valid out 1: read return.
REQ-010 SHALL have ports app_addr out ADDR_W, app_cmd out 3, app_en out 1, app_wdf_data out DATA_W, app_wdf_wren out 1, app_wdf_end out 1: MIG command/write.
REQ-011 SHALL have ports app_rdy in 1, app_wdf_rdy in 1, app_rd_data in DATA_W, app_rd_data_valid in 1: MIG status/read.
REQ-012 SHALL have port rd_outstanding out $clog2(MAX_OUT)+1: reads issued, data not yet returned.

Function
REQ-013 SHALL implement states S_CALIB, S_IDLE, S_WRITE, S_READ.
REQ-014 S_CALIB: no grants, no acks, app_en=0; move to S_IDLE on the cycle init_calib_complete=1.
REQ-015 S_IDLE: on grant, SHALL capture requester addr (and wr_data for writes) into app_addr/app_wdf_data, pulse the matching ack for exactly that cycle, and enter S_WRITE or S_READ next cycle.
REQ-016 Requester SHALL hold req/addr/data until ack; it may change them the cycle after ack.
REQ-017 S_WRITE: app_en=1, app_wdf_wren=1, app_wdf_end=app_wdf_wren, app_cmd=3'b000; held stable until a cycle with app_rdy=1 and app_wdf_rdy=1, then S_IDLE.
REQ-018 S_READ: app_en=1, app_wdf_wren=0, app_cmd=3'b001; held stable until a cycle with app_rdy=1, then S_IDLE.
REQ-019 Latency: grant cycle N -> app_en=1 at N+1; peak throughput one command per 2 cycles.
REQ-020 Read grant SHALL be blocked while rd_outstanding == MAX_OUT; writes are unaffected.
REQ-021 rd_outstanding SHALL +1 on read acceptance, -1 on app_rd_data_valid, unchanged when both occur in the same cycle; it SHALL never wrap.
REQ-022 rd_data/rd_valid SHALL register app_rd_data/app_rd_data_valid with one-cycle latency, in return order.
REQ-023 app_rd_data_valid with rd_outstanding==0 SHALL still be forwarded, and the counter SHALL stay 0.
REQ-024 init_calib_complete falling outside S_CALIB SHALL be ignored; the current command completes.

Reset
REQ-025 Reset assertion SHALL asynchronously force S_CALIB, app_en=0, app_wdf_wren=0, app_cmd=3'b000, app_addr=0, app_wdf_data=0, acks=0, rd_valid=0, rd_data=0, rd_outstanding=0, RR pointer = write-last.
REQ-026 Reset mid-command SHALL drop the command without a completion indication.

Configuration
REQ-027 With MIG_ARB_RR_EN defined: round-robin; when both request in S_IDLE, the grant goes to the port not served last; a lone requester is always granted.
REQ-028 Without MIG_ARB_RR_EN: fixed priority, read wins over write; no pointer state is synthesized.

Structure
REQ-029 Package mig_arb_pkg SHALL hold the state enum, CMD_WRITE=3'b000, CMD_READ=3'b001, and the default ADDR_W/DATA_W.
REQ-030 The outstanding-read counter SHALL be sub-module mig_arb_rd_tracker (inc, dec, full, count).

Verification
REQ-031 init_calib_complete=0 for 50 cycles with wr_req=1 -> no wr_ack, app_en=0; calib=1 -> wr_ack 1 cycle later and app_en the cycle after.
REQ-032 Write addr 0x10, data 0x2, app_wdf_rdy=0 for 5 cycles -> app_en/app_wdf_wren/app_addr/app_wdf_data held stable for 5 cycles, S_IDLE the cycle after rdy.
REQ-033 Both req held continuously, RR build, 8 grants -> strictly alternating acks, starting with read after reset; fixed build -> 8 rd_acks, 0 wr_acks.
REQ-034 Read burst of 20 with app_rd_data_valid held 0 -> exactly 16 rd_acks, rd_outstanding=16; one valid -> one more rd_ack.
REQ-035 Read acceptance and app_rd_data_valid in the same cycle at count 5 -> count stays 5; rd_data equals app_rd_data one cycle later.
REQ-036 sys_rst low during S_WRITE -> app_en=0 immediately (no ui_clk edge needed); after release, S_CALIB.
